gpr_file: RTL and testbench

- Responder end of the register-file write interface. It consumes the 3-bit write command, the GPR write data and the STATUS write data produced by the execute-stage write control.
- Holds the PIC16C5x file space: INDF, TMR0, PCL, STATUS, FSR, I/O window and general-purpose RAM.
- Resolves direct and indirect (FSR) addressing.
- Returns read data, STATUS and FSR to the ALU and write control, and forwards PCL and I/O writes to their owners.

---
 rtl/gpr_file_pkg.sv | 46 ++++
 rtl/gpr_file_ram.sv | 26 ++
 rtl/gpr_file.sv | 156 +++++++++++++++
 tb/tb_gpr_file.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gpr_file_pkg.sv
// Shared constants for the PIC16C5x register file: widths, file addresses,
// write-command bits and STATUS bit positions. GPR_BANKING_EN selects RAM depth.
package gpr_file_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned INST_WIDTH = 12;
    localparam int unsigned WC_WIDTH   = 3;
    localparam int unsigned IO_AW      = 2;

    localparam logic [DATA_WIDTH-1:0] STATUS_RESET = 8'h18;

    localparam logic [ADDR_WIDTH-1:0] ADDR_INDF   = 5'd0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_TMR0   = 5'd1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_PCL    = 5'd2;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = 5'd3;
    localparam logic [ADDR_WIDTH-1:0] ADDR_FSR    = 5'd4;
    localparam logic [ADDR_WIDTH-1:0] ADDR_PORTA  = 5'd5;
    localparam logic [ADDR_WIDTH-1:0] ADDR_PORTB  = 5'd6;
    localparam logic [ADDR_WIDTH-1:0] ADDR_PORTC  = 5'd7;
    localparam logic [ADDR_WIDTH-1:0] GPR_BASE    = 5'd8;
    localparam logic [ADDR_WIDTH-1:0] BANK_BASE   = 5'd16;

    localparam int unsigned WC_ADDR   = 2;
    localparam int unsigned WC_GPR    = 1;
    localparam int unsigned WC_STATUS = 0;

    localparam int unsigned STATUS_C  = 0;
    localparam int unsigned STATUS_DC = 1;
    localparam int unsigned STATUS_Z  = 2;
    localparam int unsigned STATUS_PD = 3;
    localparam int unsigned STATUS_TO = 4;

`ifdef GPR_BANKING_EN
    localparam int unsigned RAM_DEPTH = 72;
`else
    localparam int unsigned RAM_DEPTH = 24;
`endif
    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);

    // True for the three I/O port addresses
    function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
        return (a >= ADDR_PORTA) && (a <= ADDR_PORTC);
    endfunction

endpackage

// File: rtl/gpr_file_ram.sv
// General-purpose RAM: synchronous write, asynchronous read, cleared on reset.
// Depth comes from gpr_file_pkg (24 bytes, or 72 with GPR_BANKING_EN).
module gpr_ram
    import gpr_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [RAM_AW-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RAM_DEPTH); i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/gpr_file.sv
// PIC16C5x file register space: special registers, I/O window and RAM with
// direct/indirect addressing. GPR_BANKING_EN enables PIC16C57 FSR banking.
module gpr_file
    import gpr_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INST_WIDTH-1:0] irIn,
    input  logic [WC_WIDTH-1:0]   writeCommand,
    input  logic [DATA_WIDTH-1:0] gprWriteDataIn,
    input  logic [DATA_WIDTH-1:0] statusWriteDataIn,
    input  logic                  tmr0IncIn,
    input  logic [DATA_WIDTH-1:0] pcLowIn,
    input  logic [DATA_WIDTH-1:0] ioReadDataIn,
    output logic [DATA_WIDTH-1:0] gprReadDataOut,
    output logic [DATA_WIDTH-1:0] gprStatusOut,
    output logic [DATA_WIDTH-1:0] fsrOut,
    output logic                  pclWriteOut,
    output logic [DATA_WIDTH-1:0] pclDataOut,
    output logic                  ioWriteOut,
    output logic [IO_AW-1:0]      ioAddrOut,
    output logic [DATA_WIDTH-1:0] ioDataOut
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] fsr_q, fsr_d;
    logic [DATA_WIDTH-1:0] tmr0_q, tmr0_d;
    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic                  pcl_we_q, pcl_we_d;
    logic [DATA_WIDTH-1:0] pcl_data_q, pcl_data_d;
    logic                  io_we_q, io_we_d;
    logic [IO_AW-1:0]      io_addr_q, io_addr_d;
    logic [DATA_WIDTH-1:0] io_data_q, io_data_d;

    logic [ADDR_WIDTH-1:0] ea;
    logic                  gpr_we;
    logic                  ram_we;
    logic [RAM_AW-1:0]     ram_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] fsr_view;

    wire unused_bits = ^{irIn[INST_WIDTH-1:ADDR_WIDTH], statusWriteDataIn[STATUS_TO:STATUS_PD]};

    // Effective address; an indirect access with FSR[4:0]==0 lands on INDF, which is null
    always_comb begin
        ea     = (addr_q == ADDR_INDF) ? fsr_q[ADDR_WIDTH-1:0] : addr_q;
        gpr_we = writeCommand[WC_GPR] && (ea != ADDR_INDF);
        ram_we = gpr_we && (ea >= GPR_BASE);
`ifdef GPR_BANKING_EN
        fsr_view = {1'b1, fsr_q[6:0]};
        if (ea < GPR_BASE)       ram_idx = '0;
        else if (ea < BANK_BASE) ram_idx = RAM_AW'(ea - GPR_BASE);
        else                     ram_idx = RAM_AW'({fsr_q[6:5], ea[3:0]}) + RAM_AW'(8);
`else
        fsr_view = {3'b111, fsr_q[ADDR_WIDTH-1:0]};
        ram_idx  = (ea >= GPR_BASE) ? RAM_AW'(ea - GPR_BASE) : '0;
`endif
    end

    gpr_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (gprWriteDataIn),
        .rdata (ram_rdata)
    );

    // Zero-latency read mux
    always_comb begin
        gprReadDataOut = '0;
        case (ea)
            ADDR_INDF:   gprReadDataOut = '0;
            ADDR_TMR0:   gprReadDataOut = tmr0_q;
            ADDR_PCL:    gprReadDataOut = pcLowIn;
            ADDR_STATUS: gprReadDataOut = status_q;
            ADDR_FSR:    gprReadDataOut = fsr_view;
            default:     gprReadDataOut = is_io(ea) ? ioReadDataIn : ram_rdata;
        endcase
    end

    // Next-state for special registers and write strobes
    always_comb begin
        addr_d     = addr_q;
        fsr_d      = fsr_q;
        tmr0_d     = tmr0_q;
        status_d   = status_q;
        pcl_we_d   = 1'b0;
        pcl_data_d = pcl_data_q;
        io_we_d    = 1'b0;
        io_addr_d  = io_addr_q;
        io_data_d  = io_data_q;

        if (writeCommand[WC_ADDR]) addr_d = irIn[ADDR_WIDTH-1:0];

        if (tmr0IncIn) tmr0_d = tmr0_q + DATA_WIDTH'(1);

        if (writeCommand[WC_STATUS]) begin
            status_d[STATUS_Z:STATUS_C] = statusWriteDataIn[STATUS_Z:STATUS_C];
            status_d[7:5]               = statusWriteDataIn[7:5];
        end

        // A GPR write overrides the upper STATUS bits taken from the flag path
        if (gpr_we) begin
            case (ea)
                ADDR_TMR0:   tmr0_d = gprWriteDataIn;
                ADDR_PCL: begin
                    pcl_we_d   = 1'b1;
                    pcl_data_d = gprWriteDataIn;
                end
                ADDR_STATUS: status_d[7:5] = gprWriteDataIn[7:5];
                ADDR_FSR:    fsr_d = gprWriteDataIn;
                default: begin
                    if (is_io(ea)) begin
                        io_we_d   = 1'b1;
                        io_addr_d = IO_AW'(ea - ADDR_PORTA);
                        io_data_d = gprWriteDataIn;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            fsr_q      <= '0;
            tmr0_q     <= '0;
            status_q   <= STATUS_RESET;
            pcl_we_q   <= 1'b0;
            pcl_data_q <= '0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_data_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            fsr_q      <= fsr_d;
            tmr0_q     <= tmr0_d;
            status_q   <= status_d;
            pcl_we_q   <= pcl_we_d;
            pcl_data_q <= pcl_data_d;
            io_we_q    <= io_we_d;
            io_addr_q  <= io_addr_d;
            io_data_q  <= io_data_d;
        end
    end

    assign gprStatusOut = status_q;
    assign fsrOut       = fsr_q;
    assign pclWriteOut  = pcl_we_q;
    assign pclDataOut   = pcl_data_q;
    assign ioWriteOut   = io_we_q;
    assign ioAddrOut    = io_addr_q;
    assign ioDataOut    = io_data_q;

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file (default, unbanked build): directed vector
// table, strobe/reset sequences, then random traffic against a file-space model.
module tb_gpr_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] irIn = '0;
    logic [2:0]  writeCommand = '0;
    logic [7:0]  gprWriteDataIn = '0;
    logic [7:0]  statusWriteDataIn = '0;
    logic        tmr0IncIn = 1'b0;
    logic [7:0]  pcLowIn = '0;
    logic [7:0]  ioReadDataIn = '0;
    logic [7:0]  gprReadDataOut, gprStatusOut, fsrOut, pclDataOut, ioDataOut;
    logic        pclWriteOut, ioWriteOut;
    logic [1:0]  ioAddrOut;

    int checks = 0;
    int errors = 0;

    gpr_file dut (
        .clk(clk), .rst_n(rst_n), .irIn(irIn), .writeCommand(writeCommand),
        .gprWriteDataIn(gprWriteDataIn), .statusWriteDataIn(statusWriteDataIn),
        .tmr0IncIn(tmr0IncIn), .pcLowIn(pcLowIn), .ioReadDataIn(ioReadDataIn),
        .gprReadDataOut(gprReadDataOut), .gprStatusOut(gprStatusOut), .fsrOut(fsrOut),
        .pclWriteOut(pclWriteOut), .pclDataOut(pclDataOut), .ioWriteOut(ioWriteOut),
        .ioAddrOut(ioAddrOut), .ioDataOut(ioDataOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, take the edge, return to idle 1 time unit later
    task automatic cyc(input logic [2:0] wc, input logic [11:0] ir, input logic [7:0] gd,
                       input logic [7:0] sd, input logic inc);
        writeCommand = wc; irIn = ir; gprWriteDataIn = gd; statusWriteDataIn = sd; tmr0IncIn = inc;
        @(posedge clk);
        #1;
        writeCommand = '0; tmr0IncIn = 1'b0;
    endtask

    // Reference model: the file space as a plain 32-entry array plus latch/strobe state
    logic [7:0] m_file [32];
    logic [4:0] m_addr;
    logic       m_pcl_we, m_io_we;
    logic [7:0] m_pcl_data, m_io_data;
    logic [1:0] m_io_addr;

    function automatic logic [4:0] m_ea();
        return (m_addr == 5'd0) ? m_file[4][4:0] : m_addr;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] pcl, input logic [7:0] io);
        logic [4:0] e;
        e = m_ea();
        if (e == 5'd0) return 8'h00;
        if (e == 5'd2) return pcl;
        if (e == 5'd4) return m_file[4] | 8'hE0;
        if (e >= 5'd5 && e <= 5'd7) return io;
        return m_file[e];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_file[i] = 8'h00;
        m_file[3] = 8'h18;
        m_addr = '0; m_pcl_we = 0; m_io_we = 0; m_pcl_data = 0; m_io_data = 0; m_io_addr = 0;
    endtask

    task automatic m_step(input logic [2:0] wc, input logic [11:0] ir, input logic [7:0] gd,
                          input logic [7:0] sd, input logic inc);
        int e;
        logic tmr_written;
        e = int'(m_ea());
        tmr_written = 0;
        m_pcl_we = 0; m_io_we = 0;
        if (wc[0]) m_file[3] = {sd[7:5], m_file[3][4:3], sd[2:0]};
        if (wc[1] && e != 0) begin
            if (e == 1) begin m_file[1] = gd; tmr_written = 1; end
            else if (e == 2) begin m_pcl_we = 1; m_pcl_data = gd; end
            else if (e == 3) m_file[3][7:5] = gd[7:5];
            else if (e >= 5 && e <= 7) begin m_io_we = 1; m_io_data = gd; m_io_addr = 2'(e - 5); end
            else m_file[e] = gd;
        end
        if (inc && !tmr_written) m_file[1] = m_file[1] + 8'd1;
        if (wc[2]) m_addr = ir[4:0];
    endtask

    typedef struct {
        logic [2:0]  wc;
        logic [11:0] ir;
        logic [7:0]  gd;
        logic [7:0]  sd;
        logic        inc;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_st;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic [2:0] wc, input logic [11:0] ir, input logic [7:0] gd,
                        input logic [7:0] sd, input logic inc, input logic [7:0] rd, input logic [7:0] st);
        vec_t v;
        v.wc = wc; v.ir = ir; v.gd = gd; v.sd = sd; v.inc = inc; v.exp_rd = rd; v.exp_st = st;
        vecs.push_back(v);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        chk("reset_status", gprStatusOut, 8'h18);
        chk("reset_fsr", fsrOut, 8'h00);
        chk("reset_read_null", gprReadDataOut, 8'h00);
        chk("reset_strobes", {6'b0, pclWriteOut, ioWriteOut}, 8'h00);

        //      wc      ir       gd     sd     inc  read   status
        addv(3'b100, 12'h003, 8'h00, 8'h00, 0, 8'h18, 8'h18);
        addv(3'b100, 12'hF04, 8'h00, 8'h00, 0, 8'hE0, 8'h18);
        addv(3'b100, 12'h00A, 8'h00, 8'h00, 0, 8'h00, 8'h18);
        addv(3'b010, 12'h000, 8'h5A, 8'h00, 0, 8'h5A, 8'h18);
        addv(3'b100, 12'h004, 8'h00, 8'h00, 0, 8'hE0, 8'h18);
        addv(3'b010, 12'h000, 8'h0A, 8'h00, 0, 8'hEA, 8'h18);
        addv(3'b100, 12'h000, 8'h00, 8'h00, 0, 8'h5A, 8'h18);
        addv(3'b100, 12'h004, 8'h00, 8'h00, 0, 8'hEA, 8'h18);
        addv(3'b010, 12'h000, 8'h00, 8'h00, 0, 8'hE0, 8'h18);
        addv(3'b100, 12'h000, 8'h00, 8'h00, 0, 8'h00, 8'h18);
        addv(3'b010, 12'h000, 8'hFF, 8'h00, 0, 8'h00, 8'h18);
        addv(3'b100, 12'h00A, 8'h00, 8'h00, 0, 8'h5A, 8'h18);
        addv(3'b100, 12'h003, 8'h00, 8'h00, 0, 8'h18, 8'h18);
        addv(3'b011, 12'h000, 8'hE0, 8'h04, 0, 8'hFC, 8'hFC);
        addv(3'b001, 12'h000, 8'h00, 8'hA3, 0, 8'hBB, 8'hBB);
        addv(3'b010, 12'h000, 8'hFF, 8'h00, 0, 8'hFB, 8'hFB);
        addv(3'b100, 12'h001, 8'h00, 8'h00, 0, 8'h00, 8'hFB);
        addv(3'b010, 12'h000, 8'hFF, 8'h00, 0, 8'hFF, 8'hFB);
        addv(3'b000, 12'h000, 8'h00, 8'h00, 1, 8'h00, 8'hFB);
        addv(3'b010, 12'h000, 8'h10, 8'h00, 1, 8'h10, 8'hFB);
        addv(3'b000, 12'h000, 8'h00, 8'h00, 1, 8'h11, 8'hFB);
        addv(3'b110, 12'h00B, 8'h77, 8'h00, 0, 8'h00, 8'hFB);
        addv(3'b100, 12'h001, 8'h00, 8'h00, 0, 8'h77, 8'hFB);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].wc, vecs[i].ir, vecs[i].gd, vecs[i].sd, vecs[i].inc);
            chk($sformatf("vec%0d_read", i), gprReadDataOut, vecs[i].exp_rd);
            chk($sformatf("vec%0d_status", i), gprStatusOut, vecs[i].exp_st);
        end

        // PCL read path and write strobe
        pcLowIn = 8'h5C;
        cyc(3'b100, 12'h002, 8'h00, 8'h00, 0);
        chk("pcl_read", gprReadDataOut, 8'h5C);
        chk("pcl_idle", {7'b0, pclWriteOut}, 8'h00);
        cyc(3'b010, 12'h000, 8'h33, 8'h00, 0);
        chk("pcl_strobe", {7'b0, pclWriteOut}, 8'h01);
        chk("pcl_data", pclDataOut, 8'h33);
        cyc(3'b000, 12'h000, 8'h00, 8'h00, 0);
        chk("pcl_strobe_drop", {7'b0, pclWriteOut}, 8'h00);

        // I/O read path and write strobe
        ioReadDataIn = 8'hC3;
        cyc(3'b100, 12'h006, 8'h00, 8'h00, 0);
        chk("io_read", gprReadDataOut, 8'hC3);
        cyc(3'b010, 12'h000, 8'h44, 8'h00, 0);
        chk("io_strobe", {7'b0, ioWriteOut}, 8'h01);
        chk("io_addr", {6'b0, ioAddrOut}, 8'h01);
        chk("io_data", ioDataOut, 8'h44);
        cyc(3'b000, 12'h000, 8'h00, 8'h00, 0);
        chk("io_strobe_drop", {7'b0, ioWriteOut}, 8'h00);

        // Reset asserted mid-pulse drops both strobes at once
        cyc(3'b010, 12'h000, 8'h55, 8'h00, 0);
        chk("io_strobe2", {7'b0, ioWriteOut}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pulse_io", {7'b0, ioWriteOut}, 8'h00);
        chk("rst_mid_pulse_pcl", {7'b0, pclWriteOut}, 8'h00);
        chk("rst_mid_status", gprStatusOut, 8'h18);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Random traffic against the model
        m_reset();
        for (int n = 0; n < 600; n++) begin
            logic [2:0]  wc;
            logic [11:0] ir;
            logic [7:0]  gd, sd;
            logic        inc;
            wc = 3'($urandom); ir = 12'($urandom); gd = 8'($urandom);
            sd = 8'($urandom); inc = 1'($urandom);
            pcLowIn = 8'($urandom); ioReadDataIn = 8'($urandom);
            writeCommand = wc; irIn = ir; gprWriteDataIn = gd; statusWriteDataIn = sd; tmr0IncIn = inc;
            #1;
            chk("rnd_read", gprReadDataOut, m_read(pcLowIn, ioReadDataIn));
            m_step(wc, ir, gd, sd, inc);
            cyc(wc, ir, gd, sd, inc);
            chk("rnd_status", gprStatusOut, m_file[3]);
            chk("rnd_fsr", fsrOut, m_file[4]);
            chk("rnd_pcl_we", {7'b0, pclWriteOut}, {7'b0, m_pcl_we});
            chk("rnd_io_we", {7'b0, ioWriteOut}, {7'b0, m_io_we});
            if (m_pcl_we) chk("rnd_pcl_data", pclDataOut, m_pcl_data);
            if (m_io_we) begin
                chk("rnd_io_data", ioDataOut, m_io_data);
                chk("rnd_io_addr", {6'b0, ioAddrOut}, {6'b0, m_io_addr});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
